pipe_hazard_ctrl: RTL and testbench

Central sequencing controller for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers). It detects load-use hazards, squashes wrong-path instructions on a taken branch, and freezes the pipeline while a data-memory access is pending. It drives per-register write-enable and flush controls, runs a memory-wait watchdog, and keeps saturating stall and flush statistics counters.

---
 rtl/pipe_ctrl_pkg.sv | 25 ++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 20 ++
 rtl/pipe_hazard_ctrl.sv | 117 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: FSM states,
// the zero-register constant and the pipeline control-bundle widths.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Control bundle widths carried by ID/EX, EX/MEM and MEM/WB; a bubble zeroes these.
  localparam int EX_CTRL_W  = 8;
  localparam int MEM_CTRL_W = 5;
  localparam int WB_CTRL_W  = 2;

  function automatic logic load_use_hit(input logic       mem_read,
                                        input logic [4:0] rd,
                                        input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return mem_read && (rd != REG_ZERO) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                    cnt_q <= '0;
    else if (inc_i && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencer: memory freeze with watchdog, branch squash,
// load-use stall, plus saturating stall/flush statistics.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             ex_mem_read_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             mem_access_i,
  input  logic             mem_ready_i,
  input  logic             branch_taken_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             exmem_flush_o,
  output logic             pipe_freeze_o,
  output logic             memwb_bubble_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_stall, load_use, br_flush;

  assign mem_stall = (state_q == RUN      && mem_access_i && !mem_ready_i) ||
                     (state_q == MEM_WAIT && !mem_ready_i);
  assign load_use  = load_use_hit(ex_mem_read_i, ex_rd_i, id_rs1_i, id_rs2_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_flush_o   = 1'b0;
    exmem_flush_o  = 1'b0;
    pipe_freeze_o  = 1'b0;
    memwb_bubble_o = 1'b0;
    br_flush       = 1'b0;
    if (!rst_i) begin
      // Hold everything quiet with bubbles while reset is asserted.
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      ifid_flush_o   = 1'b1;
      idex_flush_o   = 1'b1;
      exmem_flush_o  = 1'b1;
      pipe_freeze_o  = 1'b1;
      memwb_bubble_o = 1'b1;
    end else if (state_q == HALT || mem_stall) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      pipe_freeze_o  = 1'b1;
      memwb_bubble_o = 1'b1;
      if (state_q == RUN) begin
        state_d = MEM_WAIT;
        wait_d  = WAIT_W'(1);
      end else if (state_q == MEM_WAIT) begin
        if (wait_q == WAIT_W'(MAX_WAIT)) state_d = HALT;
        else                             wait_d  = wait_q + 1'b1;
      end
    end else begin
      if (state_q == MEM_WAIT) begin
        state_d = RUN;
        wait_d  = '0;
      end
      // A branch frozen in EX/MEM resolves here on the release cycle too.
      if (branch_taken_i) begin
        br_flush      = 1'b1;
        ifid_flush_o  = 1'b1;
        idex_flush_o  = 1'b1;
        exmem_flush_o = 1'b1;
      end else if (load_use) begin
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
        idex_flush_o = 1'b1;
      end
    end
  end

  assign halted_o = (state_q == HALT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_i),
    .inc_i  (rst_i && state_q != HALT && !pc_write_o),
    .cnt_o  (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_i),
    .inc_i  (br_flush),
    .cnt_o  (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench: a default-sized controller and a small one
// (MAX_WAIT=4, CNT_W=2) run side by side on the same stimulus.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1, rs2, rd;
  logic       mread, macc, mrdy, br;

  logic        a_pc, a_ifw, a_iff, a_idf, a_exf, a_frz, a_bub, a_halt;
  logic [15:0] a_stall, a_flush;
  logic        b_pc, b_ifw, b_iff, b_idf, b_exf, b_frz, b_bub, b_halt;
  logic [1:0]  b_stall, b_flush;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MAX_WAIT(16), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .ex_mem_read_i(mread), .ex_rd_i(rd), .mem_access_i(macc),
    .mem_ready_i(mrdy), .branch_taken_i(br),
    .pc_write_o(a_pc), .ifid_write_o(a_ifw), .ifid_flush_o(a_iff),
    .idex_flush_o(a_idf), .exmem_flush_o(a_exf), .pipe_freeze_o(a_frz),
    .memwb_bubble_o(a_bub), .halted_o(a_halt),
    .stall_cnt_o(a_stall), .flush_cnt_o(a_flush)
  );

  pipe_hazard_ctrl #(.MAX_WAIT(4), .CNT_W(2)) u_small (
    .clk_i(clk), .rst_i(rst_n), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .ex_mem_read_i(mread), .ex_rd_i(rd), .mem_access_i(macc),
    .mem_ready_i(mrdy), .branch_taken_i(br),
    .pc_write_o(b_pc), .ifid_write_o(b_ifw), .ifid_flush_o(b_iff),
    .idex_flush_o(b_idf), .exmem_flush_o(b_exf), .pipe_freeze_o(b_frz),
    .memwb_bubble_o(b_bub), .halted_o(b_halt),
    .stall_cnt_o(b_stall), .flush_cnt_o(b_flush)
  );

  typedef enum {K_IDLE, K_LU, K_MEM, K_FLUSH, K_HALT, K_RST} kind_e;

  typedef struct {
    logic [6:0]  ctl;
    logic        halted;
    logic [15:0] stall;
    logic [15:0] flush;
    logic [6:0]  ctl_s;
    logic        halted_s;
    logic [1:0]  stall_s;
    logic [1:0]  flush_s;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, failures = 0;
  int   e_stall = 0, e_flush = 0, e_stall_s = 0, e_flush_s = 0;

  // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, freeze, bubble}
  function automatic logic [6:0] ctl_of(input kind_e k);
    case (k)
      K_IDLE:  return 7'b1100000;
      K_LU:    return 7'b0001000;
      K_MEM:   return 7'b0000011;
      K_HALT:  return 7'b0000011;
      K_FLUSH: return 7'b1111100;
      default: return 7'b0011111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] r1, input logic [4:0] r2, input logic mr,
                        input logic [4:0] d, input logic ma, input logic rdy, input logic b);
    rs1 = r1; rs2 = r2; mread = mr; rd = d; macc = ma; mrdy = rdy; br = b;
  endtask

  task automatic step(input string tag, input kind_e k, input kind_e ks);
    exp_t e, o;
    e.ctl      = ctl_of(k);
    e.halted   = (k == K_HALT);
    e.stall    = (k == K_RST) ? 16'd0 : 16'(e_stall);
    e.flush    = (k == K_RST) ? 16'd0 : 16'(e_flush);
    e.ctl_s    = ctl_of(ks);
    e.halted_s = (ks == K_HALT);
    e.stall_s  = (ks == K_RST) ? 2'd0 : 2'(e_stall_s);
    e.flush_s  = (ks == K_RST) ? 2'd0 : 2'(e_flush_s);
    sb.push_back(e);
    @(negedge clk);
    o = sb.pop_front();
    chk({tag, ".ctl"},      {25'd0, a_pc, a_ifw, a_iff, a_idf, a_exf, a_frz, a_bub}, {25'd0, o.ctl});
    chk({tag, ".halted"},   {31'd0, a_halt}, {31'd0, o.halted});
    chk({tag, ".stall"},    {16'd0, a_stall}, {16'd0, o.stall});
    chk({tag, ".flush"},    {16'd0, a_flush}, {16'd0, o.flush});
    chk({tag, ".s_ctl"},    {25'd0, b_pc, b_ifw, b_iff, b_idf, b_exf, b_frz, b_bub}, {25'd0, o.ctl_s});
    chk({tag, ".s_halted"}, {31'd0, b_halt}, {31'd0, o.halted_s});
    chk({tag, ".s_stall"},  {30'd0, b_stall}, {30'd0, o.stall_s});
    chk({tag, ".s_flush"},  {30'd0, b_flush}, {30'd0, o.flush_s});
    if (k == K_RST) begin e_stall = 0; e_flush = 0; end
    if (k == K_LU || k == K_MEM) e_stall++;
    if (k == K_FLUSH) e_flush++;
    if (ks == K_RST) begin e_stall_s = 0; e_flush_s = 0; end
    if ((ks == K_LU || ks == K_MEM) && e_stall_s < 3) e_stall_s++;
    if (ks == K_FLUSH && e_flush_s < 3) e_flush_s++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    repeat (3) step("reset", K_RST, K_RST);
    rst_n = 1'b1;
    repeat (2) step("idle", K_IDLE, K_IDLE);

    set_in(5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0);
    step("loaduse", K_LU, K_LU);
    set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step("lu_after", K_IDLE, K_IDLE);
    set_in(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
    step("lu_x0", K_IDLE, K_IDLE);

    set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    repeat (4) step("memwait", K_MEM, K_MEM);
    mrdy = 1'b1;
    step("mem_release", K_IDLE, K_IDLE);
    macc = 1'b0;
    step("mem_after", K_IDLE, K_IDLE);

    set_in(5'd5, 5'd2, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1);
    step("br_lu", K_FLUSH, K_FLUSH);
    set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step("br_after", K_IDLE, K_IDLE);

    set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    step("br_frozen", K_MEM, K_MEM);
    set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    step("br_release", K_FLUSH, K_FLUSH);
    br = 1'b0;
    step("br2_after", K_IDLE, K_IDLE);

    set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    repeat (5) step("wd_wait", K_MEM, K_MEM);
    repeat (3) step("wd_halt", K_MEM, K_HALT);
    rst_n = 1'b0;
    #1;
    chk("async_rst.s_halted", {31'd0, b_halt}, 32'd0);
    chk("async_rst.ctl", {25'd0, a_pc, a_ifw, a_iff, a_idf, a_exf, a_frz, a_bub}, 32'h1f);
    chk("async_rst.stall", {16'd0, a_stall}, 32'd0);
    chk("async_rst.s_stall", {30'd0, b_stall}, 32'd0);
    e_stall = 0; e_flush = 0; e_stall_s = 0; e_flush_s = 0;
    set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step("rst_hold", K_RST, K_RST);
    rst_n = 1'b1;
    step("post_rst", K_IDLE, K_IDLE);

    for (int i = 0; i < 5; i++) begin
      set_in(5'd7, 5'd3, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0);
      step("sat_lu", K_LU, K_LU);
      set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      step("sat_idle", K_IDLE, K_IDLE);
    end
    chk("sat.stall", {16'd0, a_stall}, 32'd5);
    chk("sat.s_stall", {30'd0, b_stall}, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
